// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
package fetch_unit_pkg;

  localparam int REG_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    ERR   = 2'd2
  } fetch_state_e;

  localparam logic [REG_WIDTH-1:0] NOP = '0;

endpackage

// File: rtl/fetch_unit.sv
// PC register and one-request-at-a-time instruction fetch sequencer.
// Holds a fetched word for decode and advances the PC when it is consumed.
module fetch_unit #(
  parameter int                      REG_WIDTH = fetch_unit_pkg::REG_WIDTH,
  parameter logic [REG_WIDTH-1:0]    RESET_PC  = '0,
  parameter int                      TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [REG_WIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [REG_WIDTH-1:0] imem_rdata,
  output logic [REG_WIDTH-1:0] instr,
  output logic                 instr_valid,
  output logic [REG_WIDTH-1:0] inc_pc,
  input  logic                 stall,
  input  logic                 pcsrc,
  input  logic [REG_WIDTH-1:0] new_pc,
  output logic                 fetch_err
);
  import fetch_unit_pkg::*;

  localparam int                 TIMER_W    = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  fetch_state_e         state;
  logic [REG_WIDTH-1:0] pc;
  logic [REG_WIDTH-1:0] instr_q;
  logic [TIMER_W-1:0]   timer;

  // Timer holds (FETCH cycle - 1); a miss in cycle TIMEOUT halts on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr_q <= REG_WIDTH'(NOP);
      timer   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            timer   <= '0;
            state   <= VALID;
          end else if (timer == TIMER_LAST) begin
            state <= ERR;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        VALID: begin
          if (!stall) begin
            if (pcsrc) begin
              // A misaligned target leaves the PC untouched so it can be inspected.
              if (new_pc[1:0] != 2'b00) begin
                state <= ERR;
              end else begin
                pc    <= new_pc;
                state <= FETCH;
              end
            end else begin
              pc    <= inc_pc;
              state <= FETCH;
            end
          end
        end
        ERR:     state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

  assign imem_req    = (state == FETCH) && !rst;
  assign imem_addr   = pc;
  assign inc_pc      = pc + REG_WIDTH'(4);
  assign instr       = instr_q;
  assign instr_valid = (state == VALID);
  assign fetch_err   = (state == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests and the
// expected (address, word) pairs are queued when each ack is driven.
module tb_fetch_unit;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] inc_pc;
  logic        stall;
  logic        pcsrc;
  logic [31:0] new_pc;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_pc;
  int          errors = 0;
  int          checks = 0;

  fetch_unit #(
    .REG_WIDTH(32),
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .inc_pc     (inc_pc),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .new_pc     (new_pc),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: answers the current request after 'waits' idle FETCH cycles.
  task automatic serve_fetch(input int waits);
    exp_t e;
    imem_ack = 1'b0;
    repeat (waits) tick();
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    e.addr     = exp_pc;
    e.word     = mem_word(exp_pc);
    exp_q.push_back(e);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic consume_instr(input logic redirect, input logic [31:0] target);
    stall  = 1'b0;
    pcsrc  = redirect;
    new_pc = target;
    tick();
    stall  = 1'b1;
    pcsrc  = 1'b0;
    new_pc = '0;
    if (!redirect) exp_pc = exp_pc + 32'd4;
    else if (target[1:0] == 2'b00) exp_pc = target;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    exp_pc = RESET_PC;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b1; pcsrc = 1'b0; new_pc = '0;
    tick();
    tick();
    checks++;
    if ({imem_req, instr_valid, fetch_err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {imem_req, instr_valid, fetch_err});
    end
    checks++;
    if ({instr, imem_addr, inc_pc} !== {32'h0, RESET_PC, RESET_PC + 32'd4}) begin
      errors++;
      $display("[TB] FAIL reset_regs: got %h %h %h expected 0 %h %h", instr, imem_addr, inc_pc, RESET_PC, RESET_PC + 32'd4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_req: got %b expected 1", imem_req);
    end
    exp_pc = RESET_PC;
    exp_q.delete();
  endtask

  task automatic test_zero_wait();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, exp_pc}) begin
        errors++;
        $display("[TB] FAIL zw_fetch%0d: got req=%b vld=%b addr=%h expected 1 0 %h", i, imem_req, instr_valid, imem_addr, exp_pc);
      end
      serve_fetch(0);
      e = exp_q.pop_front();
      checks++;
      if ({instr_valid, imem_req, instr, inc_pc} !== {1'b1, 1'b0, e.word, e.addr + 32'd4}) begin
        errors++;
        $display("[TB] FAIL zw_valid%0d: got vld=%b req=%b instr=%h inc=%h expected 1 0 %h %h", i, instr_valid, imem_req, instr, inc_pc, e.word, e.addr + 32'd4);
      end
      consume_instr(1'b0, 32'h0);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    serve_fetch(1);
    e = exp_q.pop_front();
    pcsrc  = 1'b1;
    new_pc = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({instr_valid, imem_req, instr, imem_addr} !== {1'b1, 1'b0, e.word, e.addr}) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got vld=%b req=%b instr=%h addr=%h expected 1 0 %h %h", i, instr_valid, imem_req, instr, imem_addr, e.word, e.addr);
      end
    end
    pcsrc  = 1'b0;
    new_pc = '0;
    consume_instr(1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, e.addr + 32'd4}) begin
      errors++;
      $display("[TB] FAIL stall_release: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, e.addr + 32'd4);
    end
  endtask

  task automatic test_wait_boundary();
    exp_t e;
    serve_fetch(TIMEOUT - 1);
    e = exp_q.pop_front();
    checks++;
    if ({instr_valid, fetch_err, instr} !== {1'b1, 1'b0, e.word}) begin
      errors++;
      $display("[TB] FAIL late_ack: got vld=%b err=%b instr=%h expected 1 0 %h", instr_valid, fetch_err, instr, e.word);
    end
    consume_instr(1'b0, 32'h0);
  endtask

  task automatic test_redirect();
    exp_t e;
    pcsrc  = 1'b1;
    new_pc = 32'h0000_0300;
    tick();
    pcsrc  = 1'b0;
    new_pc = '0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin
      errors++;
      $display("[TB] FAIL pcsrc_in_fetch: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, exp_pc);
    end
    serve_fetch(0);
    e = exp_q.pop_front();
    checks++;
    if (instr !== e.word) begin
      errors++;
      $display("[TB] FAIL redir_instr: got %h expected %h", instr, e.word);
    end
    consume_instr(1'b1, 32'h0000_0100);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0100}) begin
      errors++;
      $display("[TB] FAIL redir_addr: got req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    serve_fetch(0);
    e = exp_q.pop_front();
    consume_instr(1'b1, 32'hFFFF_FFFC);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL wrap_addr: got %h expected fffffffc", imem_addr);
    end
    serve_fetch(2);
    e = exp_q.pop_front();
    checks++;
    if ({inc_pc, instr} !== {32'h0, e.word}) begin
      errors++;
      $display("[TB] FAIL wrap_inc: got inc=%h instr=%h expected 0 %h", inc_pc, instr, e.word);
    end
    consume_instr(1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL wrap_next: got req=%b addr=%h expected 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    serve_fetch(0);
    e = exp_q.pop_front();
    consume_instr(1'b1, 32'h0000_0102);
    checks++;
    if ({fetch_err, imem_req, instr_valid, imem_addr} !== {3'b100, exp_pc}) begin
      errors++;
      $display("[TB] FAIL misalign_err: got err=%b req=%b vld=%b addr=%h expected 1 0 0 %h", fetch_err, imem_req, instr_valid, imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (3) tick();
    imem_ack   = 1'b0;
    checks++;
    if ({fetch_err, instr_valid, instr, imem_addr} !== {2'b10, e.word, exp_pc}) begin
      errors++;
      $display("[TB] FAIL err_ignores_ack: got err=%b vld=%b instr=%h addr=%h expected 1 0 %h %h", fetch_err, instr_valid, instr, imem_addr, e.word, exp_pc);
    end
    do_reset();
    checks++;
    if ({fetch_err, imem_req, imem_addr} !== {2'b01, RESET_PC}) begin
      errors++;
      $display("[TB] FAIL err_reset: got err=%b req=%b addr=%h expected 0 1 %h", fetch_err, imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_timeout();
    imem_ack = 1'b0;
    repeat (TIMEOUT - 1) tick();
    checks++;
    if ({fetch_err, imem_req} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL timeout_last_cycle: got err=%b req=%b expected 0 1", fetch_err, imem_req);
    end
    tick();
    checks++;
    if ({fetch_err, imem_req, instr_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL timeout_err: got err=%b req=%b vld=%b expected 1 0 0", fetch_err, imem_req, instr_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (4) tick();
    imem_ack   = 1'b0;
    checks++;
    if ({fetch_err, imem_req, instr_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: got err=%b req=%b vld=%b expected 1 0 0", fetch_err, imem_req, instr_valid);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    serve_fetch(0);
    void'(exp_q.pop_front());
    consume_instr(1'b0, 32'h0);
    imem_ack = 1'b0;
    repeat (2) tick();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL req_during_rst: got %b expected 0", imem_req);
    end
    tick();
    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    #1;
    checks++;
    if ({instr_valid, imem_req, fetch_err, imem_addr, instr} !== {3'b010, RESET_PC, 32'h0}) begin
      errors++;
      $display("[TB] FAIL rst_mid_wait: got vld=%b req=%b err=%b addr=%h instr=%h expected 0 1 0 %h 0", instr_valid, imem_req, fetch_err, imem_addr, instr, RESET_PC);
    end
    exp_pc = RESET_PC;
    exp_q.delete();
    serve_fetch(0);
    e = exp_q.pop_front();
    checks++;
    if ({instr_valid, instr, inc_pc} !== {1'b1, e.word, RESET_PC + 32'd4}) begin
      errors++;
      $display("[TB] FAIL post_rst_fetch: got vld=%b instr=%h inc=%h expected 1 %h %h", instr_valid, instr, inc_pc, e.word, RESET_PC + 32'd4);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_wait_boundary();
    test_redirect();
    test_wrap();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter register and instruction-fetch sequencer for the single-cycle-issue MIPS core. Holds the architectural PC and issues one instruction-memory request at a time. Presents the fetched word together with `inc_pc` (PC+4) to decode and the next-PC logic. On each consumed instruction it loads either the redirect target (`new_pc`, when `pcsrc`=1) or PC+4.

## Interface

Parameters:
- `REG_WIDTH`, 32: datapath and address width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Must be word-aligned.
- `TIMEOUT`, 16: maximum number of FETCH cycles to wait for `imem_ack`. Legal range 2..256.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: byte address of the word being fetched; equals `pc`.
- `imem_ack`  in  1: `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32: fetched instruction word.
- `instr`  out  32: latched instruction presented to decode.
- `instr_valid`  out  1: `instr` and `inc_pc` are valid.
- `inc_pc`  out  32: `pc + 4`, to next-PC logic.
- `stall`  in  1: downstream is not ready to consume `instr`.
- `pcsrc`  in  1: take `new_pc` instead of PC+4.
- `new_pc`  in  32: redirect target from next-PC logic.
- `fetch_err`  out  1: sticky error (timeout or misaligned target).

## Operation

- States:
  - FETCH: request outstanding.
  - VALID: instruction held for decode.
  - ERR: halted.
- FETCH:
  - `imem_req` = 1.
  - On `imem_ack`: `instr` <= `imem_rdata`, clear the timer, go to VALID.
  - Otherwise the timer increments. If the timer reaches `TIMEOUT-1` with no ack, go to ERR.
- VALID:
  - `instr_valid` = 1 and `imem_req` = 0.
  - While `stall`=1, hold `instr` and `pc` unchanged.
  - On `stall`=0 (instruction consumed), sample `pcsrc`:
    - `pcsrc`=1: `pc` <= `new_pc`.
    - `pcsrc`=0: `pc` <= `pc + 4`.
  - Then go to FETCH.
- Misaligned redirect: consumed with `pcsrc`=1 and `new_pc[1:0]` != 0. The PC is not updated and the block goes to ERR.
- ERR:
  - `fetch_err` = 1, `imem_req` = 0, `instr_valid` = 0.
  - Exit only by reset. `imem_ack` is ignored in this state.
- Arithmetic: `inc_pc` = `pc + 4` modulo 2^32, so 32'hFFFF_FFFC wraps to 0. `pc[1:0]` is always 00.
- `pcsrc` and `new_pc` are ignored outside VALID, and ignored in VALID while `stall`=1.
- `imem_ack` outside FETCH (a late or spurious ack) is ignored.

## Timing

- Reset, on the edge with `rst`=1:
  - `pc` = `RESET_PC`
  - state = FETCH
  - timer = 0
  - `instr` = 32'h0000_0000 (a MIPS nop)
- `imem_req` = (state==FETCH) && !`rst`, so no request is driven during a reset cycle. The first request appears in the first cycle with `rst`=0.
- Reset takes priority over every other event, including an ack, a redirect or ERR.
- Outputs are combinational from registers only:
  - `imem_addr` = `pc`
  - `inc_pc` = `pc`+4
  - `instr_valid` = (state==VALID)
  - `fetch_err` = (state==ERR)
- Latency:
  - An ack in the first FETCH cycle raises `instr_valid` on the next cycle.
  - The minimum is 2 cycles per instruction (FETCH, VALID).
  - Each memory wait cycle adds 1 cycle.
- The PC update and the return to FETCH occur on the same edge. The next `imem_addr` is visible in the following cycle.
- Timeout:
  - An ack in FETCH cycle k, with k ≤ `TIMEOUT`, is accepted.
  - If no ack arrives by FETCH cycle `TIMEOUT`, state goes to ERR on the following edge.
- `instr` is stable for the entire VALID period.

## Structure

- Shared package/header:
  - `REG_WIDTH`
  - state encoding: FETCH=2'd0, VALID=2'd1, ERR=2'd2
  - NOP constant 32'h0
- Timer width = clog2(`TIMEOUT`).
- No sub-module is required. The PC adder is a single `+ 4`. Implement flat: one state register, a `pc` register, an `instr` register and the timer.

## Test plan

- Reset then zero-wait memory: `RESET_PC`=0.
  - Expected `imem_addr` sequence: 0, 4, 8, ...
  - `instr_valid` pulses every 2nd cycle.
  - `inc_pc` = 4 while `instr` from address 0 is valid.
- `stall` held 3 cycles in VALID: `instr` and `pc` stay constant, and `imem_req`=0 throughout. After release, the next fetch is at `pc`+4.
- Redirect: `pcsrc`=1, `new_pc`=32'h0000_0100 on consume. The next `imem_addr` is 0x100. A `pcsrc` pulse during FETCH has no effect.
- Wrap: `pc`=32'hFFFF_FFFC. `inc_pc` = 0, and the next fetch address is 0.
- Errors:
  - Ack withheld for `TIMEOUT` cycles: `fetch_err`=1 and `imem_req`=0 persist until `rst`.
  - A redirect to 0x102 leads to ERR with `pc` unchanged.
- Reset mid-wait: assert `rst` during FETCH with an ack in the same cycle. The ack is ignored, `pc`=`RESET_PC`, and the next request is at `RESET_PC`.
